uart_transmitter: RTL
=====================

// Module: uart_transmitter
// PURPOSE
//   Buffered UART transmitter; upstream of uart_receiver, driving its uart_rx line.
//   Accepts bytes through a valid/ready handshake into a small FIFO.
//   Serialises each byte as start(0), 8 data bits data[8] first down to data[1], then stop(1).
//   One bit per baud_rate_signal edge; frame format matches what uart_receiver samples.
// PARAMETERS
//   FIFO_DEPTH  4   byte entries in TX FIFO; power of two, >=2
//   STOP_BITS   1   stop-bit periods per frame; 1 or 2
// PORTS
//   baud_rate_signal  in   1                         clock; one rising edge per bit period
//   rst_n             in   1                         asynchronous reset, active low
//   tx_data           in   [8:1]                     byte to send; bit 8 transmitted first
//   tx_valid          in   1                         tx_data valid this cycle
//   tx_ready          out  1                         FIFO can accept; = (fifo_count != FIFO_DEPTH)
//   uart_tx           out  1                         serial line, registered, idles high
//   tx_busy           out  1                         FSM not in IDLE
//   fifo_count        out  $clog2(FIFO_DEPTH+1)      entries buffered; excludes byte on the line
// BEHAVIOUR
//   Reset (async, rst_n low): uart_tx=1, state=IDLE, FIFO flushed, fifo_count=0,
//     tx_ready=1, tx_busy=0. Reset mid-frame aborts the frame; line returns high at once.
//   Push: tx_valid && tx_ready at an edge writes tx_data at wr_ptr. wr_ptr wraps modulo FIFO_DEPTH.
//   Full (tx_ready=0): tx_data is not written. Producer holds tx_valid/tx_data until accepted.
//   Pop: FSM loads head into shift reg; rd_ptr wraps modulo FIFO_DEPTH.
//   Simultaneous push and pop: both take effect; fifo_count unchanged.
//   Push while full never overwrites. Pop while empty never occurs.
//   FSM (state names = what uart_tx currently carries):
//     IDLE : uart_tx=1. If fifo_count!=0 at an edge: pop, uart_tx<=0, ->START.
//     START: ->DATA, bit_idx<=8, uart_tx<=shift[8].
//     DATA : if bit_idx==1: uart_tx<=1, stop_cnt<=1, ->STOP.
//            else: bit_idx<=bit_idx-1, uart_tx<=shift[bit_idx-1].
//     STOP : if stop_cnt<STOP_BITS: stop_cnt+1, stay.
//            elif fifo_count!=0: pop, uart_tx<=0, ->START (back-to-back, no idle gap).
//            else ->IDLE.
//   Frame length: 1+8+STOP_BITS bit periods, each exactly one baud edge apart.
//   Latency: byte pushed into empty FIFO while IDLE at edge k -> start bit driven from edge k+1.
//   Byte order on line equals push order; no drops, no duplicates.
//   tx_busy registered with state: 1 from the pop edge until the edge returning to IDLE.
//   bit_idx is 4 bits; stop_cnt is 2 bits.
//   Unused/illegal state encodings recover to IDLE with uart_tx=1.
// TESTING
//   1 Reset: assert rst_n=0 mid-frame -> uart_tx=1, tx_busy=0, fifo_count=0, tx_ready=1 immediately.
//   2 Single byte 8'hA5 pushed at edge k -> uart_tx from edge k+1: 0,1,0,1,0,0,1,0,1,1 then idle high;
//     tx_busy high exactly 10 edges.
//   3 Hold tx_valid with 6 bytes 8'h01..8'h06 from IDLE -> 5 accepted on consecutive edges;
//     tx_ready low while fifo_count=4; sixth accepted only after next pop;
//     six frames back-to-back in order, no idle gap.
//   4 Loopback into uart_receiver, bytes 8'h00,8'hFF,8'h3C back-to-back -> three valid_data pulses
//     with data equal to each byte, in order.
//   5 STOP_BITS=2, two bytes -> 11-period frames; two high periods between last data bit
//     and next start.
//   6 Push and pop on same edge at fifo_count=2 -> fifo_count stays 2; both bytes later sent correctly.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter: FIFO-buffered UART transmitter, MSB-first frames clocked by the baud edge
module uart_transmitter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                              baud_rate_signal,
  input  logic                              rst_n,
  input  logic [8:1]                        tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              uart_tx,
  output logic                              tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [1:0] SB = 2'(STOP_BITS);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [8:1] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [8:1] shift, shift_n;
  logic [3:0] bit_idx, bit_idx_n, prev_idx;
  logic [1:0] stop_cnt, stop_cnt_n;
  logic tx_n, push, pop, has_data;
  assign tx_ready = fifo_count != FULL;
  assign push     = tx_valid && tx_ready;
  assign has_data = fifo_count != '0;
  assign tx_busy  = state != IDLE;
  assign prev_idx = bit_idx - 4'd1;
  // FIFO storage; pointers alone define validity, so the array needs no reset
  always_ff @(posedge baud_rate_signal)
    if (push) mem[wr_ptr] <= tx_data;
  // FIFO pointers and occupancy; push and pop on one edge cancel in the count
  always_ff @(posedge baud_rate_signal or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  // Frame sequencer; each state name is what the line carries during it
  always_comb begin
    state_n    = state;
    tx_n       = uart_tx;
    shift_n    = shift;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (has_data) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        state_n   = DATA;
        bit_idx_n = 4'd8;
        tx_n      = shift[8];
      end
      DATA: begin
        if (bit_idx == 4'd1) begin
          tx_n       = 1'b1;
          stop_cnt_n = 2'd1;
          state_n    = STOP;
        end else begin
          bit_idx_n = prev_idx;
          tx_n      = shift[prev_idx];
        end
      end
      STOP: begin
        if (stop_cnt < SB) stop_cnt_n = stop_cnt + 2'd1;
        else if (has_data) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n    = 1'b0;
          state_n = START;
        end else begin
          tx_n    = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end
  // Sequencer registers; reset drops any frame in flight and forces the line high
  always_ff @(posedge baud_rate_signal or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= '0;
    end else begin
      state    <= state_n;
      uart_tx  <= tx_n;
      shift    <= shift_n;
      bit_idx  <= bit_idx_n;
      stop_cnt <= stop_cnt_n;
    end
endmodule
